// File: rtl/teclado_pkg.sv
// Shared types, key codes and the matrix-to-code map for the ATM keypad front-end.
package teclado_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} estado_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/teclado_escaner.sv
// Column synchronizer, row scanner and press/release debounce FSM.
// Emits the accepted key code with a one-cycle tecla_evento pulse (high during EMIT).
module teclado_escaner
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] code,
  output logic       tecla_evento
);

  localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  estado_t         state;
  logic [3:0]      sync1, sync2;
  logic [1:0]      row;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   deb_cnt;
  logic            valid_c;
  logic [1:0]      col_c;
  logic [3:0]      code_c;

  // Exactly one low column is a press; anything else is "no key".
  always_comb begin
    valid_c = 1'b0;
    col_c   = 2'd0;
    case (sync2)
      4'b1110: begin valid_c = 1'b1; col_c = 2'd0; end
      4'b1101: begin valid_c = 1'b1; col_c = 2'd1; end
      4'b1011: begin valid_c = 1'b1; col_c = 2'd2; end
      4'b0111: begin valid_c = 1'b1; col_c = 2'd3; end
      default: ;
    endcase
    code_c = key_map(row, col_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1        <= 4'hF;
      sync2        <= 4'hF;
      state        <= SCAN;
      row          <= 2'd0;
      filas        <= 4'b1110;
      scan_cnt     <= '0;
      deb_cnt      <= '0;
      code         <= 4'd0;
      tecla_evento <= 1'b0;
    end else begin
      sync1        <= columnas;
      sync2        <= sync1;
      tecla_evento <= 1'b0;
      case (state)
        SCAN: begin
          // Synchronized columns lag a row change, so ignore them until they settle.
          if (valid_c && scan_cnt >= SW'(SYNC_STAGES)) begin
            state   <= DEBOUNCE;
            code    <= code_c;
            deb_cnt <= '0;
          end else if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            row      <= row + 2'd1;
            filas    <= {filas[2:0], filas[3]};
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (!valid_c || code_c != code) begin
            state    <= SCAN;
            deb_cnt  <= '0;
            scan_cnt <= '0;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state        <= EMIT;
            deb_cnt      <= '0;
            tecla_evento <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        EMIT: begin
          state   <= RELEASE;
          deb_cnt <= '0;
        end
        RELEASE: begin
          if (valid_c) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state    <= SCAN;
            deb_cnt  <= '0;
            scan_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: rtl/teclado_cajero.sv
// ATM keypad front-end: PIN digit strobes in PIN mode, decimal amount assembly in amount mode.
module teclado_cajero
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned MAX_DIGITS      = 9
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  COLUMNAS,
  input  logic        MODO_MONTO,
  output logic [3:0]  FILAS,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  logic [3:0]    code;
  logic          tecla_evento;
  logic          modo_q;
  logic [31:0]   acc;
  logic [CW-1:0] count;

  teclado_escaner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_escaner (
    .clk         (CLK),
    .rst         (RESET),
    .columnas    (COLUMNAS),
    .filas       (FILAS),
    .code        (code),
    .tecla_evento(tecla_evento)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DIGITO     <= 4'd0;
      DIGITO_STB <= 1'b0;
      MONTO      <= 32'd0;
      MONTO_STB  <= 1'b0;
      modo_q     <= 1'b0;
      acc        <= 32'd0;
      count      <= '0;
    end else begin
      DIGITO_STB <= 1'b0;
      MONTO_STB  <= 1'b0;
      modo_q     <= MODO_MONTO;
      // A mode switch abandons any partially typed amount.
      if (MODO_MONTO != modo_q) begin
        acc   <= 32'd0;
        count <= '0;
      end else if (tecla_evento) begin
        if (!MODO_MONTO) begin
          if (is_digit(code)) begin
            DIGITO     <= code;
            DIGITO_STB <= 1'b1;
          end
        end else if (is_digit(code)) begin
          if (count < CW'(MAX_DIGITS)) begin
            acc   <= acc * 32'd10 + 32'(code);
            count <= count + CW'(1);
          end
        end else if (code == KEY_STAR) begin
          acc   <= 32'd0;
          count <= '0;
        end else if (code == KEY_HASH && count != '0) begin
          MONTO     <= acc;
          MONTO_STB <= 1'b1;
          acc       <= 32'd0;
          count     <= '0;
        end
      end
    end
  end

endmodule

// File: doc/teclado_cajero.md
Name: teclado_cajero

Overview:
- Keypad front-end for the ATM controller. It scans a 4x4 matrix keypad, synchronizes and debounces key presses, and drives the controller's PIN-entry inputs (DIGITO/DIGITO_STB).
- In amount mode it assembles a decimal amount and drives MONTO/MONTO_STB.
- It sits directly upstream of the ATM controller, and its outputs connect to that controller's inputs of the same name.

Parameters:
SCAN_CYCLES, 16, clock cycles each row stays driven while no key is detected
DEBOUNCE_CYCLES, 1000, consecutive cycles a key code (or release) must be stable before it is accepted
MAX_DIGITS, 9, maximum amount digits accepted (9 decimal digits always fit in 32 bits)

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-high reset
COLUMNAS  input  4  keypad columns, active-low, asynchronous to CLK
MODO_MONTO  input  1  0 = PIN entry, 1 = amount entry (from controller state)
FILAS  output  4  row drive, active-low one-hot
DIGITO  output  4  last accepted PIN digit (0-9)
DIGITO_STB  output  1  one-cycle pulse, DIGITO valid
MONTO  output  32  last entered amount, binary
MONTO_STB  output  1  one-cycle pulse, MONTO valid

Behaviour:
- Reset (asynchronous, active-high): FILAS=4'b1110, DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, accumulator=0, digit count=0, state=SCAN. Reset asserted mid-operation aborts any debounce or entry; no strobe is issued.
- COLUMNAS passes through a 2-flop synchronizer before any use.
- Key map, row r (FILAS bit r low), column c (COLUMNAS bit c low):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Internal codes: digits 0-9, A-D=4'hA-4'hD, *=4'hE, #=4'hF.
- Exactly one column low means a valid press. Zero columns low, or more than one, means no key.
- FSM states:
  - SCAN: rotate FILAS every SCAN_CYCLES cycles (r0→r1→r2→r3→r0). On a valid press, freeze the row and go to DEBOUNCE.
  - DEBOUNCE: count cycles while the code is unchanged. A code change or no key returns to SCAN (counter cleared, row kept). After DEBOUNCE_CYCLES stable cycles, go to EMIT.
  - EMIT: exactly one cycle; process the key (rules below); go to RELEASE.
  - RELEASE: wait for "no key" stable for DEBOUNCE_CYCLES cycles, then go to SCAN. A held key never re-strobes.
- PIN mode (MODO_MONTO=0), in EMIT:
  - Digit key: DIGITO<=code, DIGITO_STB=1 on the cycle after EMIT.
  - All other keys: ignored.
- Amount mode (MODO_MONTO=1), in EMIT:
  - Digit key: if count<MAX_DIGITS, acc<=acc*10+d (32-bit) and count++; otherwise ignored.
  - *: acc<=0, count<=0.
  - # with count>0: MONTO<=acc, MONTO_STB=1 on the cycle after EMIT, acc<=0, count<=0.
  - # with count=0: ignored.
  - A-D: ignored.
  - DIGITO_STB is never asserted in this mode.
- Any MODO_MONTO change clears acc and count.
- Strobes are registered, last exactly one cycle, and are never asserted together.
- DIGITO and MONTO hold their values until the next strobe.
- Latency: a clean press on the driven row strobes 2 (sync) + DEBOUNCE_CYCLES + 2 cycles after COLUMNAS falls.

Decomposition:
- Package teclado_pkg:
  - state enum {SCAN, DEBOUNCE, EMIT, RELEASE}
  - key code constants (KEY_STAR, KEY_HASH, KEY_A-KEY_D)
  - key map function (row,col→code)
- Sub-module teclado_escaner (synchronizer, row scan, debounce FSM). It outputs code plus a one-cycle tecla_evento pulse.
- Top-level teclado_cajero holds the mode logic, the accumulator and the output registers.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
1. PIN mode, hold "3" (r0,c2) for 40 cycles, release, then hold "5" → DIGITO=3 with a single DIGITO_STB pulse, then DIGITO=5 with a single pulse; nothing while held.
2. Bounce: toggle c0 on r1 every 3 cycles for 60 cycles → no strobe; then hold it stable → exactly one DIGITO_STB with DIGITO=4.
3. Amount mode, keys 1,0,0,0,0,# → MONTO=10000, one MONTO_STB pulse, DIGITO_STB never asserted.
4. Amount mode, ten presses of 9 then # → MONTO=999999999. Then keys 4,2,*,7,# → MONTO=7.
5. Two columns low on one row → no strobe. # with empty entry → no MONTO_STB. Keys A/B/C/D in PIN mode → no strobe.
6. Assert RESET during DEBOUNCE of "8" and mid-amount (acc=12) → all outputs 0, FILAS=1110, no strobe. After release, keys 3,# → MONTO=3.
